// File: rtl/wb_i2c_slave.sv
// Wishbone-attached 7-bit-addressed I2C target with one-byte RX/TX holding registers,
// sticky status flags and a level interrupt. SDA is driven open-drain via sda_oe.
module wb_i2c_slave #(
    parameter logic [6:0]  default_addr = 7'h42,
    parameter int unsigned sync_stages  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        scl,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        intr
);

    localparam int unsigned SYNC_N = (sync_stages < 2) ? 2 : sync_stages;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_RXDATA = 2'd2;
    localparam logic [1:0] REG_TXDATA = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_N-1:0] scl_sync_q, sda_sync_q;
    logic              scl_prev_q, sda_prev_q;
    logic              scl_s, sda_s;
    logic              scl_rise_c, scl_fall_c, start_c, stop_c;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  shift_q, shift_d;
    logic               ack_q, ack_d;
    logic               sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d;
    logic               rw_q, rw_d;

    logic               rx_valid_q, rx_valid_d;
    logic               tx_valid_q, tx_valid_d;
    logic               overrun_q, overrun_d;
    logic               underrun_q, underrun_d;
    logic               stop_seen_q, stop_seen_d;
    logic [BYTE_W-1:0]  rxdata_q, rxdata_d;
    logic [BYTE_W-1:0]  txdata_q, txdata_d;
    logic               en_q, en_d;
    logic               ien_q, ien_d;
    logic [6:0]         own_addr_q, own_addr_d;
    logic               wb_ack_q, wb_ack_d;
    logic [31:0]        wb_dat_q, wb_dat_d;
    logic               intr_q, intr_d;

    logic               rx_store_c, ovr_set_c, tx_load_c, stop_set_c;
    logic [BYTE_W-1:0]  rx_byte_c, tx_byte_c;
    logic               wb_req_c, wb_wr_c, wb_rd_c;
    logic [1:0]         reg_sel_c;
    logic [31:0]        rd_data_c;
    logic               unused_c;

    assign unused_c = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:15]};

    // Pad synchronizers and one-cycle-delayed copies for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_N-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_N-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s      = scl_sync_q[SYNC_N-1];
    assign sda_s      = sda_sync_q[SYNC_N-1];
    assign scl_rise_c = scl_s & ~scl_prev_q;
    assign scl_fall_c = ~scl_s & scl_prev_q;
    assign start_c    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_c     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign rx_byte_c  = {shift_q[BYTE_W-2:0], sda_s};
    assign tx_byte_c  = tx_valid_q ? txdata_q : 8'hFF;

    // Protocol FSM: bits sampled on SCL rise, SDA driven only on SCL fall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;
        rx_store_c = 1'b0;
        ovr_set_c  = 1'b0;
        tx_load_c  = 1'b0;
        stop_set_c = 1'b0;

        if (start_c) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_c) begin
            state_d    = ST_IDLE;
            stop_set_c = busy_q;
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise_c) begin
                        shift_d = rx_byte_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d = '0;
                            if (en_q && (rx_byte_c[7:1] == own_addr_q)) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                                rw_d    = rx_byte_c[0];
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    // cnt 0: first fall asserts ACK; cnt 1: second fall ends the ACK slot
                    if (scl_fall_c) begin
                        if (cnt_q == '0) begin
                            sda_oe_d = 1'b1;
                            cnt_d    = CNT_W'(1);
                        end else begin
                            cnt_d = '0;
                            if (rw_q) begin
                                tx_load_c = 1'b1;
                                shift_d   = tx_byte_c;
                                sda_oe_d  = ~tx_byte_c[7];
                                state_d   = ST_TX;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = ST_RX;
                            end
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise_c) begin
                        shift_d = rx_byte_c;
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            state_d = ST_RX_ACK;
                            if (rx_valid_q) begin
                                ovr_set_c = 1'b1;
                                ack_d     = 1'b0;
                            end else begin
                                rx_store_c = 1'b1;
                                ack_d      = 1'b1;
                            end
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall_c) begin
                        if (cnt_q == '0) begin
                            sda_oe_d = ack_q;
                            cnt_d    = CNT_W'(1);
                        end else begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_RX;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_rise_c) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (scl_fall_c) begin
                        if (cnt_q == CNT_W'(8)) begin
                            sda_oe_d = 1'b0;
                            cnt_d    = '0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    // ack_q holds the sampled SDA level: 0 = controller ACK
                    if (scl_rise_c) begin
                        cnt_d = CNT_W'(1);
                        ack_d = sda_s;
                    end else if (scl_fall_c && (cnt_q == CNT_W'(1))) begin
                        cnt_d = '0;
                        if (!ack_q) begin
                            tx_load_c = 1'b1;
                            shift_d   = tx_byte_c;
                            sda_oe_d  = ~tx_byte_c[7];
                            state_d   = ST_TX;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_req_c  = wb_stb_i & wb_cyc_i & ~wb_ack_q;
    assign wb_wr_c   = wb_req_c & wb_we_i;
    assign wb_rd_c   = wb_req_c & ~wb_we_i;
    assign reg_sel_c = wb_adr_i[3:2];

    always_comb begin
        rd_data_c = '0;
        case (reg_sel_c)
            REG_CTRL:   rd_data_c = {17'd0, own_addr_q, 6'd0, ien_q, en_q};
            REG_STATUS: rd_data_c = {25'd0, rw_q, stop_seen_q, underrun_q, overrun_q,
                                     busy_q, ~tx_valid_q, rx_valid_q};
            REG_RXDATA: rd_data_c = {24'd0, rxdata_q};
            default:    rd_data_c = '0;
        endcase
    end

    // Register file: bus clears/writes first, then hardware sets so sets win
    always_comb begin
        en_d        = en_q;
        ien_d       = ien_q;
        own_addr_d  = own_addr_q;
        rx_valid_d  = rx_valid_q;
        tx_valid_d  = tx_valid_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        stop_seen_d = stop_seen_q;
        rxdata_d    = rxdata_q;
        txdata_d    = txdata_q;
        wb_ack_d    = wb_req_c;
        wb_dat_d    = wb_rd_c ? rd_data_c : 32'd0;

        if (wb_wr_c && (reg_sel_c == REG_CTRL)) begin
            en_d       = wb_dat_i[0];
            ien_d      = wb_dat_i[1];
            own_addr_d = wb_dat_i[14:8];
        end
        if (wb_wr_c && (reg_sel_c == REG_STATUS)) begin
            if (wb_dat_i[3]) overrun_d   = 1'b0;
            if (wb_dat_i[4]) underrun_d  = 1'b0;
            if (wb_dat_i[5]) stop_seen_d = 1'b0;
        end
        if (wb_rd_c && (reg_sel_c == REG_RXDATA)) begin
            rx_valid_d = 1'b0;
        end
        if (tx_load_c) begin
            tx_valid_d = 1'b0;
            if (!tx_valid_q) underrun_d = 1'b1;
        end
        if (wb_wr_c && (reg_sel_c == REG_TXDATA)) begin
            txdata_d   = wb_dat_i[7:0];
            tx_valid_d = 1'b1;
        end
        if (rx_store_c) begin
            rxdata_d   = rx_byte_c;
            rx_valid_d = 1'b1;
        end
        if (ovr_set_c)  overrun_d   = 1'b1;
        if (stop_set_c) stop_seen_d = 1'b1;

        intr_d = ien_d & (rx_valid_d | (busy_d & rw_d & ~tx_valid_d) |
                          stop_seen_d | overrun_d | underrun_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ack_q       <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            stop_seen_q <= 1'b0;
            rxdata_q    <= '0;
            txdata_q    <= '0;
            en_q        <= 1'b0;
            ien_q       <= 1'b0;
            own_addr_q  <= default_addr;
            wb_ack_q    <= 1'b0;
            wb_dat_q    <= '0;
            intr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            ack_q       <= ack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            rx_valid_q  <= rx_valid_d;
            tx_valid_q  <= tx_valid_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            stop_seen_q <= stop_seen_d;
            rxdata_q    <= rxdata_d;
            txdata_q    <= txdata_d;
            en_q        <= en_d;
            ien_q       <= ien_d;
            own_addr_q  <= own_addr_d;
            wb_ack_q    <= wb_ack_d;
            wb_dat_q    <= wb_dat_d;
            intr_q      <= intr_d;
        end
    end

    assign wb_ack_o = wb_ack_q;
    assign wb_dat_o = wb_dat_q;
    assign sda_oe   = sda_oe_q;
    assign intr     = intr_q;

endmodule
